btn_cmd_sched: RTL and testbench

- Command scheduler between the debounced button/switch front end and a shared downstream datapath port.
- Turns single-cycle button pulses into queued commands. Each command is tagged with its button index and carries the switch value captured when the pulse arrived.
- Simultaneous requesters are resolved by round-robin; commands are issued over a valid/ready handshake from a small FIFO.

---
 rtl/btn_cmd_pkg.sv | 31 +++
 rtl/cmd_fifo.sv | 53 +++++
 rtl/btn_cmd_sched.sv | 135 +++++++++++++
 tb/tb_btn_cmd_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cmd_pkg.sv
// Shared constants, command record and round-robin helper for the button command scheduler.
// The repeat delays apply only when BTN_CMD_REPEAT_EN is defined.
package btn_cmd_pkg;

   localparam int unsigned REPEAT_DLY = 50_000_000;
   localparam int unsigned REPEAT_PER = 10_000_000;

   localparam int N_BTN_DEF  = 4;
   localparam int DATA_W_DEF = 8;
   localparam int ID_W_DEF   = $clog2(N_BTN_DEF);

   typedef struct packed {
      logic [ID_W_DEF-1:0]   id;
      logic [DATA_W_DEF-1:0] data;
   } cmd_t;

   // Returns {found, index}: the first set bit of req, searching from ptr+1 modulo n.
   // The loop runs downwards so that the nearest candidate overwrites farther ones.
   function automatic logic [3:0] rr_next(input logic [7:0] req, input logic [2:0] ptr,
                                          input int n);
      logic [3:0] pick;
      int         j;
      pick = 4'd0;
      for (int k = 8; k >= 1; k--) begin
         j = (int'(ptr) + k) % n;
         if (k <= n && req[j[2:0]]) pick = {1'b1, j[2:0]};
      end
      return pick;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular-buffer command FIFO with occupancy count; head is read straight from storage.
// Push and pop may coincide at any occupancy, including full.
module cmd_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the head being popped in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + AW'(1);
         end
         if (do_pop) rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/btn_cmd_sched.sv
// Button command scheduler: pending flags per button, round-robin grant into a command FIFO.
// Define BTN_CMD_REPEAT_EN to add hold-to-repeat request generation from btn_level.
module btn_cmd_sched
   import btn_cmd_pkg::*;
#(
   parameter int N_BTN  = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int ID_W   = $clog2(N_BTN)
`ifdef BTN_CMD_REPEAT_EN
   ,
   parameter int unsigned RPT_DLY = REPEAT_DLY,
   parameter int unsigned RPT_PER = REPEAT_PER
`endif
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_BTN-1:0]         btn_pulse,
   input  logic [N_BTN-1:0]         btn_level,
   input  logic [DATA_W-1:0]        sw_val,
   output logic                     cmd_valid,
   output logic [ID_W-1:0]          cmd_id,
   output logic [DATA_W-1:0]        cmd_data,
   input  logic                     cmd_ready,
   output logic [$clog2(DEPTH):0]   cmd_count,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   logic [N_BTN-1:0]  pend;
   logic [DATA_W-1:0] pdata [N_BTN];
   logic [ID_W-1:0]   ptr;
   logic [3:0]        pick;
   logic              grant;
   logic [ID_W-1:0]   gnt_idx;
   logic [N_BTN-1:0]  gnt_vec;
   logic [N_BTN-1:0]  rpt_fire;
   logic [N_BTN-1:0]  take;
   logic [N_BTN-1:0]  ovf_set;
   logic              pop;
   logic              space;
   logic              fifo_full;
   logic              fifo_empty;

   // Handshake: a command transfers on any rising clk edge where cmd_valid && cmd_ready;
   // cmd_valid/cmd_id/cmd_data are registered and never depend on cmd_ready.
   assign cmd_valid = !fifo_empty;

   always_comb begin
      pop     = cmd_valid && cmd_ready;
      space   = !fifo_full || pop;
      pick    = rr_next(8'(pend), 3'(ptr), N_BTN);
      grant   = space && pick[3];
      gnt_idx = ID_W'(pick[2:0]);
      gnt_vec = grant ? (N_BTN'(1) << gnt_idx) : '0;
      // A flag being granted this cycle can be re-armed by a new request.
      take    = (btn_pulse | rpt_fire) & (~pend | gnt_vec);
      ovf_set = btn_pulse & pend & ~gnt_vec;
   end

`ifdef BTN_CMD_REPEAT_EN
   logic [31:0]      hold_cnt [N_BTN];
   logic [N_BTN-1:0] rpt_phase;

   always_comb begin
      rpt_fire = '0;
      for (int i = 0; i < N_BTN; i++) begin
         rpt_fire[i] = btn_level[i] && !btn_pulse[i] &&
                       (rpt_phase[i] ? (hold_cnt[i] == RPT_PER - 1)
                                     : (hold_cnt[i] == RPT_DLY - 1));
      end
   end

   // rpt_phase marks that the first (long) delay has elapsed since the last press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
         rpt_phase <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (btn_pulse[i] || !btn_level[i]) begin
               hold_cnt[i]  <= '0;
               rpt_phase[i] <= 1'b0;
            end else if (rpt_fire[i]) begin
               hold_cnt[i]  <= '0;
               rpt_phase[i] <= 1'b1;
            end else begin
               hold_cnt[i]  <= hold_cnt[i] + 32'd1;
            end
         end
      end
   end
`else
   logic unused_level;
   assign unused_level = ^btn_level;
   assign rpt_fire     = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         for (int i = 0; i < N_BTN; i++) pdata[i] <= '0;
         ptr      <= ID_W'(N_BTN - 1);
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (take[i]) begin
               pend[i]  <= 1'b1;
               pdata[i] <= sw_val;
            end else if (gnt_vec[i]) begin
               pend[i]  <= 1'b0;
            end
         end
         if (grant) ptr <= gnt_idx;
         if (|ovf_set)          overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (ID_W + DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (grant),
      .wdata ({gnt_idx, pdata[gnt_idx]}),
      .pop   (pop),
      .rdata ({cmd_id, cmd_data}),
      .count (cmd_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_btn_cmd_sched.sv
// Self-checking bench for btn_cmd_sched: directed vector table, mid-cycle reset sequence,
// randomized run against a queue-based model, and (with BTN_CMD_REPEAT_EN) a repeat sequence.
module tb_btn_cmd_sched;
   import btn_cmd_pkg::*;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int W     = $bits(cmd_t);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  btn_pulse = '0;
   logic [N-1:0]  btn_level = '0;
   logic [DW-1:0] sw_val = '0;
   logic          cmd_valid;
   logic [1:0]    cmd_id;
   logic [DW-1:0] cmd_data;
   logic          cmd_ready = 1'b0;
   logic [2:0]    cmd_count;
   logic          overflow;
   logic          clr_overflow = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   btn_cmd_sched #(
      .N_BTN  (N),
      .DATA_W (DW),
      .DEPTH  (DEPTH)
`ifdef BTN_CMD_REPEAT_EN
      ,
      .RPT_DLY(10),
      .RPT_PER(4)
`endif
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_pulse    (btn_pulse),
      .btn_level    (btn_level),
      .sw_val       (sw_val),
      .cmd_valid    (cmd_valid),
      .cmd_id       (cmd_id),
      .cmd_data     (cmd_data),
      .cmd_ready    (cmd_ready),
      .cmd_count    (cmd_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] p, input logic [DW-1:0] s, input logic r,
                        input logic c);
      btn_pulse    = p;
      sw_val       = s;
      cmd_ready    = r;
      clr_overflow = c;
   endtask

   task automatic do_reset();
      drive('0, '0, 1'b0, 1'b0);
      btn_level = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard / reference model: pending table, round-robin pointer, queue as FIFO
   logic [W-1:0]  exp_q[$];
   bit   [N-1:0]  m_pend;
   logic [DW-1:0] m_pdata [N];
   int            m_ptr;
   bit            m_ovf;

   task automatic model_reset();
      exp_q.delete();
      m_pend = '0;
      for (int i = 0; i < N; i++) m_pdata[i] = '0;
      m_ptr = N - 1;
      m_ovf = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] p, input logic [DW-1:0] s, input logic r,
                             input logic c);
      bit do_pop;
      bit has_space;
      bit ovf_hit;
      int g;
      do_pop    = (exp_q.size() != 0) && r;
      has_space = (exp_q.size() < DEPTH) || do_pop;
      g = -1;
      if (has_space) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && m_pend[j]) g = j;
         end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (g >= 0) begin
         exp_q.push_back(cmd_t'{id: 2'(g), data: m_pdata[g]});
         m_pend[g] = 1'b0;
         m_ptr     = g;
      end
      ovf_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (p[i]) begin
            if (m_pend[i]) ovf_hit = 1'b1;
            else begin
               m_pend[i]  = 1'b1;
               m_pdata[i] = s;
            end
         end
      end
      if (ovf_hit) m_ovf = 1'b1;
      else if (c)  m_ovf = 1'b0;
   endtask

   task automatic compare_model(input int cyc);
      cmd_t h;
      chk($sformatf("rnd_valid[%0d]", cyc), 32'(cmd_valid), 32'(exp_q.size() != 0));
      chk($sformatf("rnd_count[%0d]", cyc), 32'(cmd_count), 32'(exp_q.size()));
      chk($sformatf("rnd_ovf[%0d]", cyc), 32'(overflow), 32'(m_ovf));
      if (exp_q.size() != 0) begin
         h = exp_q[0];
         chk($sformatf("rnd_id[%0d]", cyc), 32'(cmd_id), 32'(h.id));
         chk($sformatf("rnd_data[%0d]", cyc), 32'(cmd_data), 32'(h.data));
      end
   endtask

   // directed vectors: inputs for one edge, expected outputs just after it
   typedef struct {
      logic [3:0] p;
      logic [7:0] sw;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [1:0] eid;
      logic [7:0] edata;
      logic [2:0] ecnt;
      logic       eovf;
   } vec_t;

   vec_t tbl [25];

   initial begin
      // burst on all buttons fills FIFO in order 0..3, then overflow / clear / set-wins
      tbl[0]  = '{4'hF, 8'h3C, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
      tbl[1]  = '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3C, 3'd1, 1'b0};
      tbl[2]  = '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3C, 3'd2, 1'b0};
      tbl[3]  = '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3C, 3'd3, 1'b0};
      tbl[4]  = '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3C, 3'd4, 1'b0};
      tbl[5]  = '{4'h1, 8'h11, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3C, 3'd4, 1'b0};
      tbl[6]  = '{4'h1, 8'h22, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3C, 3'd4, 1'b1};
      tbl[7]  = '{4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 8'h3C, 3'd4, 1'b0};
      tbl[8]  = '{4'h1, 8'h33, 1'b0, 1'b1, 1'b1, 2'd0, 8'h3C, 3'd4, 1'b1};
      // full FIFO, push and pop together, then drain
      tbl[9]  = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h3C, 3'd4, 1'b1};
      tbl[10] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 8'h3C, 3'd3, 1'b1};
      tbl[11] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 8'h3C, 3'd2, 1'b1};
      tbl[12] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h11, 3'd1, 1'b1};
      tbl[13] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};
      tbl[14] = '{4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
      // second burst from ptr=0, with a re-arm of button 1 while it is granted
      tbl[15] = '{4'hF, 8'h5A, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
      tbl[16] = '{4'h2, 8'h77, 1'b1, 1'b0, 1'b1, 2'd1, 8'h5A, 3'd1, 1'b0};
      tbl[17] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 8'h5A, 3'd1, 1'b0};
      tbl[18] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 8'h5A, 3'd1, 1'b0};
      tbl[19] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h5A, 3'd1, 1'b0};
      tbl[20] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h77, 3'd1, 1'b0};
      tbl[21] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
      // single press on button 2: valid two cycles after the pulse, one cycle wide
      tbl[22] = '{4'h4, 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
      tbl[23] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 8'hA5, 3'd1, 1'b0};
      tbl[24] = '{4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};

      do_reset();
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_count", 32'(cmd_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_id", 32'(cmd_id), 32'd0);
      chk("rst_data", 32'(cmd_data), 32'd0);

      for (int v = 0; v < 25; v++) begin
         drive(tbl[v].p, tbl[v].sw, tbl[v].rdy, tbl[v].clr);
         step();
         chk($sformatf("vec%0d_valid", v), 32'(cmd_valid), 32'(tbl[v].ev));
         chk($sformatf("vec%0d_count", v), 32'(cmd_count), 32'(tbl[v].ecnt));
         chk($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(tbl[v].eovf));
         if (tbl[v].ev) begin
            chk($sformatf("vec%0d_id", v), 32'(cmd_id), 32'(tbl[v].eid));
            chk($sformatf("vec%0d_data", v), 32'(cmd_data), 32'(tbl[v].edata));
         end
      end

      // reset pulse between edges while commands are queued and overflow is set
      do_reset();
      drive(4'hF, 8'h66, 1'b0, 1'b0);
      step();
      drive(4'hF, 8'h67, 1'b0, 1'b0);
      step();
      chk("mid_pre_ovf", 32'(overflow), 32'd1);
      chk("mid_pre_count", 32'(cmd_count), 32'd1);
      drive(4'h0, 8'h00, 1'b0, 1'b0);
      step();
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
      chk("mid_rst_count", 32'(cmd_count), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      chk("mid_rst_id", 32'(cmd_id), 32'd0);
      chk("mid_rst_data", 32'(cmd_data), 32'd0);
      rst_n = 1'b1;
      drive(4'h3, 8'h81, 1'b0, 1'b0);
      step();
      drive(4'h0, 8'h00, 1'b0, 1'b0);
      step();
      chk("post_rst_valid", 32'(cmd_valid), 32'd1);
      chk("post_rst_first_id", 32'(cmd_id), 32'd0);
      chk("post_rst_data", 32'(cmd_data), 32'h81);
      step();
      chk("post_rst_count", 32'(cmd_count), 32'd2);
      drive(4'h0, 8'h00, 1'b1, 1'b0);
      step();
      chk("post_rst_second_id", 32'(cmd_id), 32'd1);
      chk("post_rst_count2", 32'(cmd_count), 32'd1);

      // randomized run against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0]  p;
         logic [DW-1:0] s;
         logic          r;
         logic          cl;
         p  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         s  = 8'($urandom_range(0, 255));
         r  = 1'($urandom_range(0, 1));
         cl = ($urandom_range(0, 9) == 0);
         drive(p, s, r, cl);
         model_step(p, s, r, cl);
         step();
         compare_model(c);
      end

`ifdef BTN_CMD_REPEAT_EN
      // hold button 1: commands after edges +1, +11, +15, +19; level drop stops repeats
      do_reset();
      btn_level = 4'h2;
      drive(4'h2, 8'h42, 1'b1, 1'b0);
      step();
      drive(4'h0, 8'h42, 1'b1, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         logic exp_v;
         btn_level = (k <= 20) ? 4'h2 : 4'h0;
         step();
         exp_v = (k == 1) || (k == 11) || (k == 15) || (k == 19);
         chk($sformatf("rpt_valid[%0d]", k), 32'(cmd_valid), 32'(exp_v));
         if (exp_v) begin
            chk($sformatf("rpt_id[%0d]", k), 32'(cmd_id), 32'd1);
            chk($sformatf("rpt_data[%0d]", k), 32'(cmd_data), 32'h42);
         end
         chk($sformatf("rpt_ovf[%0d]", k), 32'(overflow), 32'd0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
